// File: rtl/alu_1bit.sv
// alu_1bit: registered single-bit ALU slice (NOR/XOR/ADD/SUB) chained through cin/cout.
// Define ALU_1BIT_STICKY_EN to add the cout_sticky flag and its sticky_clr input.
module alu_1bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] s_op,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
`ifdef ALU_1BIT_STICKY_EN
    input  logic       sticky_clr,
    output logic       cout_sticky,
`endif
    output logic       z,
    output logic       cout,
    output logic       valid
);
    logic bb, z_d, cout_d, z_q, cout_q, valid_q;
    // SUB reuses the adder with b inverted; cout = 1 then means no borrow
    always_comb begin
        bb     = s_op[0] ? ~b : b;
        z_d    = s_op[1] ? a ^ bb ^ cin : (s_op[0] ? a ^ b : ~(a | b));
        cout_d = s_op[1] & ((a & bb) | (a & cin) | (bb & cin));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q     <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                z_q    <= z_d;
                cout_q <= cout_d;
            end
        end
    end
`ifdef ALU_1BIT_STICKY_EN
    logic sticky_q, sticky_d;
    always_comb sticky_d = sticky_clr ? 1'b0 : (en ? sticky_q | cout_d : sticky_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
    assign cout_sticky = sticky_q;
`endif
    assign z     = z_q;
    assign cout  = cout_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_alu_1bit.sv
// tb_alu_1bit: scoreboard bench for alu_1bit with an arithmetic reference model.
module tb_alu_1bit;
    logic       clk = 0, rst_n = 0, en = 0, a = 0, b = 0, cin = 0;
    logic [1:0] s_op = 0;
    logic       z, cout, valid;
    int         n_chk = 0, n_fail = 0;
    logic [1:0] exp_q[$];
    logic [1:0] last = 0;
`ifdef ALU_1BIT_STICKY_EN
    logic sticky_clr = 0, cout_sticky, exp_sticky = 0, pend_clr = 0;
`endif

    alu_1bit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_op(s_op), .a(a), .b(b), .cin(cin),
`ifdef ALU_1BIT_STICKY_EN
        .sticky_clr(sticky_clr), .cout_sticky(cout_sticky),
`endif
        .z(z), .cout(cout), .valid(valid)
    );

    always #5 clk = ~clk;

    // returns {z, cout} from the opcode's arithmetic meaning
    function automatic logic [1:0] model(input logic [1:0] op, input logic aa, input logic bv, input logic cc);
        int s;
        case (op)
            2'b00: return {~(aa | bv), 1'b0};
            2'b01: return {aa ^ bv, 1'b0};
            2'b10: begin s = int'(aa) + int'(bv) + int'(cc); return {s[0], s[1]}; end
            default: begin s = 2 + int'(aa) - int'(bv) - (1 - int'(cc)); return {s[0], s[1]}; end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [1:0] op, input logic aa, input logic bv, input logic cc);
        @(negedge clk);
`ifdef ALU_1BIT_STICKY_EN
        chk("cout_sticky", cout_sticky, exp_sticky);
        sticky_clr = pend_clr;
`endif
        en = e; s_op = op; a = aa; b = bv; cin = cc;
        if (e) begin
            last = model(op, aa, bv, cc);
            exp_q.push_back(last);
        end
`ifdef ALU_1BIT_STICKY_EN
        exp_sticky = pend_clr ? 1'b0 : (e ? exp_sticky | last[0] : exp_sticky);
        pend_clr = 0;
`endif
    endtask

    always @(posedge clk) begin
        logic en_s;
        en_s = en;
        #1;
        if (rst_n) begin
            chk("valid", valid, en_s);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: valid with empty queue");
                end else chk("z_cout", {z, cout}, exp_q.pop_front());
            end
        end
    end

    initial begin
        en = 1; s_op = 2'b10; a = 1; b = 1; cin = 1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {z, cout, valid}, 3'b000);
        en = 0;
        #2 rst_n = 1;
        step(1, 2'b10, 1, 1, 0);
        step(1, 2'b10, 1, 1, 1);
        step(1, 2'b11, 0, 1, 1);
        step(1, 2'b11, 1, 0, 1);
        step(1, 2'b00, 0, 0, 1);
        step(1, 2'b01, 1, 0, 0);
        step(1, 2'b10, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #2 chk("hold", {z, cout, valid}, 3'b010);
        end
        step(1, 2'b10, 1, 1, 1);
        @(posedge clk);
        step(1, 2'b11, 0, 0, 0);
        #2 rst_n = 0;
        exp_q.delete();
`ifdef ALU_1BIT_STICKY_EN
        exp_sticky = 0;
`endif
        #1 chk("async_reset", {z, cout, valid}, 3'b000);
        @(negedge clk);
        chk("reset_hold", {z, cout, valid}, 3'b000);
        en = 0;
        #2 rst_n = 1;
`ifdef ALU_1BIT_STICKY_EN
        step(1, 2'b10, 1, 1, 0);
        step(1, 2'b00, 1, 0, 0);
        step(1, 2'b00, 0, 0, 0);
        pend_clr = 1;
        step(1, 2'b10, 1, 1, 1);
        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
`endif
        for (int i = 0; i < 300; i++) begin
`ifdef ALU_1BIT_STICKY_EN
            pend_clr = ($urandom_range(0, 9) == 0);
`endif
            step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        step(0, 2'b00, 0, 0, 0);
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", 4'(exp_q.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
